// File: rtl/matmul_sp_acc_if.sv
// Bus bundle between the matmul engine / bus slave and the result scratchpad.
// master drives commands, row beats and read requests; slave is the scratchpad.
interface matmul_sp_acc_if #(
    parameter int BUS_WIDTH   = 32,
    parameter int MAX_DIM     = 2,
    parameter int SP_NTARGETS = 4
);
    localparam int TW = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;
    localparam int DW = $clog2(MAX_DIM + 1);
    localparam int IW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

    logic                         start_i;
    logic                         clr_i;
    logic [TW-1:0]                tgt_i;
    logic                         acc_i;
    logic [DW-1:0]                dim_i;
    logic                         row_valid_i;
    logic                         row_ready_o;
    logic [MAX_DIM*BUS_WIDTH-1:0] row_data_i;
    logic                         rd_en_i;
    logic [TW-1:0]                rd_tgt_i;
    logic [IW-1:0]                rd_row_i;
    logic [IW-1:0]                rd_col_i;
    logic [BUS_WIDTH-1:0]         rd_data_o;
    logic                         rd_valid_o;
    logic                         busy_o;
    logic                         done_o;
    logic                         ovf_o;
    logic                         err_o;

    modport master (
        output start_i, clr_i, tgt_i, acc_i, dim_i, row_valid_i, row_data_i,
        output rd_en_i, rd_tgt_i, rd_row_i, rd_col_i,
        input  row_ready_o, rd_data_o, rd_valid_o, busy_o, done_o, ovf_o, err_o
    );

    modport slave (
        input  start_i, clr_i, tgt_i, acc_i, dim_i, row_valid_i, row_data_i,
        input  rd_en_i, rd_tgt_i, rd_row_i, rd_col_i,
        output row_ready_o, rd_data_o, rd_valid_o, busy_o, done_o, ovf_o, err_o
    );
endinterface

// File: rtl/matmul_sp_acc.sv
// Multi-target result scratchpad: row writes (overwrite/accumulate), row-wise clear,
// and an independent registered random-access read port.
module matmul_sp_acc_lane #(
    parameter int BUS_WIDTH = 32
) (
    input  logic [BUS_WIDTH-1:0] old_v,
    input  logic [BUS_WIDTH-1:0] new_v,
    input  logic                 acc,
    output logic [BUS_WIDTH-1:0] res,
    output logic                 ovf
);
    logic [BUS_WIDTH-1:0] sum;
    assign sum = old_v + new_v;
    assign res = acc ? sum : new_v;
    // Signed overflow: operands agree in sign, wrapped sum does not.
    assign ovf = acc && (old_v[BUS_WIDTH-1] == new_v[BUS_WIDTH-1])
                     && (sum[BUS_WIDTH-1] != old_v[BUS_WIDTH-1]);
endmodule

module matmul_sp_acc #(
    parameter int DATA_WIDTH  = 16,
    parameter int BUS_WIDTH   = 32,
    parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    parameter int SP_NTARGETS = 4
) (
    input logic              clk_i,
    input logic              rst_ni,
    matmul_sp_acc_if.slave   bus
);
    localparam int TW = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;
    localparam int DW = $clog2(MAX_DIM + 1);
    localparam int IW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_e;
    typedef logic [MAX_DIM-1:0][BUS_WIDTH-1:0] row_t;

    state_e        state_q, state_d;
    logic [TW-1:0] tgt_q, tgt_d;
    logic          acc_q, acc_d;
    logic [DW-1:0] dim_q, dim_d;
    logic [IW-1:0] row_cnt, cnt_d;
    logic          ovf_q, ovf_d, done_q, done_d, err_q, err_d;
    logic          wr_row, clr_row;

    row_t [MAX_DIM-1:0] mem [SP_NTARGETS];
    row_t                old_row, new_row, res_row;
    logic [MAX_DIM-1:0]  lane_ovf;
    logic [BUS_WIDTH-1:0] rd_data_q;
    logic                 rd_vld_q;
    logic                 rd_in_range;

    assign old_row = mem[tgt_q][row_cnt];
    assign new_row = row_t'(bus.row_data_i);

    for (genvar j = 0; j < MAX_DIM; j++) begin : g_lane
        matmul_sp_acc_lane #(.BUS_WIDTH(BUS_WIDTH)) u_lane (
            .old_v (old_row[j]),
            .new_v (new_row[j]),
            .acc   (acc_q),
            .res   (res_row[j]),
            .ovf   (lane_ovf[j])
        );
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        acc_d   = acc_q;
        dim_d   = dim_q;
        cnt_d   = row_cnt;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_row  = 1'b0;
        clr_row = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    // A simultaneous clear is dropped and flagged; the start still counts.
                    err_d = bus.clr_i;
                    if (bus.dim_i != '0 && 32'(bus.dim_i) <= MAX_DIM) begin
                        state_d = WRITE;
                        tgt_d   = bus.tgt_i;
                        acc_d   = bus.acc_i;
                        dim_d   = bus.dim_i;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.clr_i) begin
                    state_d = CLEAR;
                    tgt_d   = bus.tgt_i;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                err_d = bus.start_i | bus.clr_i;
                if (bus.row_valid_i) begin
                    wr_row = 1'b1;
                    if (|lane_ovf) ovf_d = 1'b1;
                    if (DW'(row_cnt) == dim_q - DW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = row_cnt + IW'(1);
                    end
                end
            end
            CLEAR: begin
                err_d   = bus.start_i | bus.clr_i;
                clr_row = 1'b1;
                if (row_cnt == IW'(MAX_DIM - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = row_cnt + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            acc_q   <= 1'b0;
            dim_q   <= '0;
            row_cnt <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            acc_q   <= acc_d;
            dim_q   <= dim_d;
            row_cnt <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < SP_NTARGETS; t++) mem[t] <= '0;
        end else if (wr_row) begin
            mem[tgt_q][row_cnt] <= res_row;
        end else if (clr_row) begin
            mem[tgt_q][row_cnt] <= '0;
        end
    end

    assign rd_in_range = 32'(bus.rd_tgt_i) < SP_NTARGETS &&
                         32'(bus.rd_row_i) < MAX_DIM && 32'(bus.rd_col_i) < MAX_DIM;

    // Read samples the pre-edge array, so a same-cycle write returns the old value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= bus.rd_en_i;
            if (bus.rd_en_i)
                rd_data_q <= rd_in_range ? mem[bus.rd_tgt_i][bus.rd_row_i][bus.rd_col_i] : '0;
        end
    end

    assign bus.row_ready_o = (state_q == WRITE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.rd_data_o   = rd_data_q;
    assign bus.rd_valid_o  = rd_vld_q;
endmodule
